// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC outputs of the program-counter stage.
// The master side (fetch/control logic) drives stall, branch and halt controls;
// the slave side (pc_sequencer) drives the PC and its status pulses.
// Optional macro PC_WRAP_COUNT_EN adds the wrap_count signal.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 48
);
    logic                stall;
    logic                branch_valid;
    logic [PC_WIDTH-1:0] branch_target;
    logic                halt_req;
    logic                resume;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic                pc_valid;
    logic                halted;
    logic                wrapped;
    logic                bad_target;
`ifdef PC_WRAP_COUNT_EN
    logic [15:0]         wrap_count;
`endif

    modport master (
        output stall,
        output branch_valid,
        output branch_target,
        output halt_req,
        output resume,
        input  pc,
        input  pc_next,
        input  pc_valid,
        input  halted,
        input  wrapped,
        input  bad_target
`ifdef PC_WRAP_COUNT_EN
        , input wrap_count
`endif
    );

    modport slave (
        input  stall,
        input  branch_valid,
        input  branch_target,
        input  halt_req,
        input  resume,
        output pc,
        output pc_next,
        output pc_valid,
        output halted,
        output wrapped,
        output bad_target
`ifdef PC_WRAP_COUNT_EN
        , output wrap_count
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the fetch stage.
// Steps by STEP modulo MEM_SIZE, honours stall, bounds-checked branch loads
// and a RUN/HALT state machine. Defining PC_WRAP_COUNT_EN adds a saturating
// 16-bit wrap_count output on the interface.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH = 48,
    parameter int unsigned MEM_SIZE = 32,
    parameter int unsigned STEP     = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [PC_WIDTH:0]   MEM_W   = (PC_WIDTH+1)'(MEM_SIZE);
    localparam logic [PC_WIDTH:0]   STEP_W  = (PC_WIDTH+1)'(STEP);
    localparam logic [PC_WIDTH-1:0] RESET_W = PC_WIDTH'(RESET_PC);

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                wrapped_q;
    logic                bad_q;

    logic [PC_WIDTH:0]   sum;
    logic                wrap_now;
    logic [PC_WIDTH-1:0] next_pc;
    logic                target_ok;
    logic                load_ok;

    // Next sequential PC: one extra bit of headroom so the wrap test cannot overflow
    always_comb begin
        sum       = {1'b0, pc_q} + STEP_W;
        wrap_now  = (sum >= MEM_W);
        next_pc   = wrap_now ? PC_WIDTH'(sum - MEM_W) : PC_WIDTH'(sum);
        target_ok = ({1'b0, bus.branch_target} < MEM_W);
        load_ok   = bus.branch_valid & target_ok;
    end

    // RUN/HALT state machine with PC register and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_W;
            wrapped_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            wrapped_q <= 1'b0;
            bad_q     <= bus.branch_valid & ~target_ok;
            case (state_q)
                RUN: begin
                    if (load_ok) begin
                        pc_q <= bus.branch_target;
                        if (bus.halt_req) begin
                            state_q <= HALT;
                        end
                    end else if (bus.halt_req) begin
                        state_q <= HALT;
                    end else if (!bus.stall) begin
                        pc_q      <= next_pc;
                        wrapped_q <= wrap_now;
                    end
                end
                HALT: begin
                    if (load_ok) begin
                        pc_q <= bus.branch_target;
                    end
                    if (bus.resume && !bus.halt_req) begin
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef PC_WRAP_COUNT_EN
    logic [15:0] wrap_cnt_q;
    logic        inc_wrap;

    assign inc_wrap = (state_q == RUN) & ~load_ok & ~bus.halt_req & ~bus.stall & wrap_now;

    // Saturating count of wrap events, cleared by reset or any legal branch load
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt_q <= 16'h0000;
        end else if (load_ok) begin
            wrap_cnt_q <= 16'h0000;
        end else if (inc_wrap && (wrap_cnt_q != 16'hFFFF)) begin
            wrap_cnt_q <= wrap_cnt_q + 16'h0001;
        end
    end

    assign bus.wrap_count = wrap_cnt_q;
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_next    = next_pc;
    assign bus.pc_valid   = (state_q == RUN) & ~bus.stall;
    assign bus.halted     = (state_q == HALT);
    assign bus.wrapped    = wrapped_q;
    assign bus.bad_target = bad_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer.
// Two instances share clk/rst: unit 0 uses STEP=1, unit 1 uses STEP=3,
// both MEM_SIZE=32, RESET_PC=0. With PC_WRAP_COUNT_EN defined the bench
// also checks wrap_count.
module tb_pc_sequencer;

    localparam int PCW = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;

    typedef struct {
        int             unit;
        string          name;
        logic [PCW-1:0] pc;
        logic [PCW-1:0] pc_next;
        logic           valid;
        logic           halted;
        logic           wrapped;
        logic           bad;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests    = 0;
    int   failures = 0;

    pc_sequencer_if #(.PC_WIDTH(PCW)) bus0 ();
    pc_sequencer_if #(.PC_WIDTH(PCW)) bus1 ();

    pc_sequencer #(.PC_WIDTH(PCW), .MEM_SIZE(32), .STEP(1), .RESET_PC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pc_sequencer #(.PC_WIDTH(PCW), .MEM_SIZE(32), .STEP(3), .RESET_PC(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [PCW-1:0] act, input logic [PCW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus0.stall = 1'b0; bus0.branch_valid = 1'b0; bus0.branch_target = '0;
        bus0.halt_req = 1'b0; bus0.resume = 1'b0;
        bus1.stall = 1'b0; bus1.branch_valid = 1'b0; bus1.branch_target = '0;
        bus1.halt_req = 1'b0; bus1.resume = 1'b0;
    endtask

    task automatic pushExpect(input int unit, input string name, input logic [PCW-1:0] pc,
                              input logic st, input logic h, input logic w, input logic b);
        exp_t e;
        int   step;
        step      = (unit == 0) ? 1 : 3;
        e.unit    = unit;
        e.name    = name;
        e.pc      = pc;
        e.pc_next = PCW'((int'(pc) + step) % 32);
        e.valid   = ~h & ~st;
        e.halted  = h;
        e.wrapped = w;
        e.bad     = b;
        sb.push_back(e);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        pushExpect(0, {name, "_u0"}, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pushExpect(1, {name, "_u1"}, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyStimulus(input int unit, input string name,
                                 input logic st, input logic bv, input logic [PCW-1:0] tgt,
                                 input logic hr, input logic rs,
                                 input logic [PCW-1:0] exp_pc, input logic exp_h,
                                 input logic exp_w, input logic exp_b);
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        if (unit == 0) begin
            bus0.stall = st; bus0.branch_valid = bv; bus0.branch_target = tgt;
            bus0.halt_req = hr; bus0.resume = rs;
        end else begin
            bus1.stall = st; bus1.branch_valid = bv; bus1.branch_target = tgt;
            bus1.halt_req = hr; bus1.resume = rs;
        end
        @(posedge clk);
        pushExpect(unit, name, exp_pc, st, exp_h, exp_w, exp_b);
    endtask

    // Monitor: after each edge, pop every pending expectation and compare
    always @(posedge clk) begin
        #1;
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.unit == 0) begin
                checkOutput({mon_e.name, ".pc"},         bus0.pc,         mon_e.pc);
                checkOutput({mon_e.name, ".pc_next"},    bus0.pc_next,    mon_e.pc_next);
                checkOutput({mon_e.name, ".pc_valid"},   PCW'(bus0.pc_valid),   PCW'(mon_e.valid));
                checkOutput({mon_e.name, ".halted"},     PCW'(bus0.halted),     PCW'(mon_e.halted));
                checkOutput({mon_e.name, ".wrapped"},    PCW'(bus0.wrapped),    PCW'(mon_e.wrapped));
                checkOutput({mon_e.name, ".bad_target"}, PCW'(bus0.bad_target), PCW'(mon_e.bad));
            end else begin
                checkOutput({mon_e.name, ".pc"},         bus1.pc,         mon_e.pc);
                checkOutput({mon_e.name, ".pc_next"},    bus1.pc_next,    mon_e.pc_next);
                checkOutput({mon_e.name, ".pc_valid"},   PCW'(bus1.pc_valid),   PCW'(mon_e.valid));
                checkOutput({mon_e.name, ".halted"},     PCW'(bus1.halted),     PCW'(mon_e.halted));
                checkOutput({mon_e.name, ".wrapped"},    PCW'(bus1.wrapped),    PCW'(mon_e.wrapped));
                checkOutput({mon_e.name, ".bad_target"}, PCW'(bus1.bad_target), PCW'(mon_e.bad));
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        clearInputs();
        doReset("reset");
`ifdef PC_WRAP_COUNT_EN
        #2;
        checkOutput("wrap_count_after_reset", PCW'(bus0.wrap_count), 48'd0);
`endif
        // free run 0..31 then back to 0 with a wrap pulse
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(0, $sformatf("freerun%0d", k), 1'b0, 1'b0, 48'd0, 1'b0, 1'b0,
                          PCW'(k % 32), 1'b0, (k == 32), 1'b0);
        end

        // STEP=3 unit: 30 -> 1 (wrap) -> 4
        applyStimulus(1, "s3_br30", 1'b0, 1'b1, 48'd30, 1'b0, 1'b0, 48'd30, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, "s3_adv1", 1'b0, 1'b0, 48'd0,  1'b0, 1'b0, 48'd1,  1'b0, 1'b1, 1'b0);
        applyStimulus(1, "s3_adv2", 1'b0, 1'b0, 48'd0,  1'b0, 1'b0, 48'd4,  1'b0, 1'b0, 1'b0);

        // stall holds, branch beats stall
        applyStimulus(0, "br5",     1'b0, 1'b1, 48'd5,  1'b0, 1'b0, 48'd5,  1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, $sformatf("stall%0d", k), 1'b1, 1'b0, 48'd0, 1'b0, 1'b0,
                          48'd5, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(0, "br20_stall", 1'b1, 1'b1, 48'd20, 1'b0, 1'b0, 48'd20, 1'b0, 1'b0, 1'b0);

        // illegal then legal branch
        applyStimulus(0, "br7",     1'b0, 1'b1, 48'd7,  1'b0, 1'b0, 48'd7,  1'b0, 1'b0, 1'b0);
        applyStimulus(0, "br40_bad",1'b0, 1'b1, 48'd40, 1'b0, 1'b0, 48'd8,  1'b0, 1'b0, 1'b1);
        applyStimulus(0, "br12",    1'b0, 1'b1, 48'd12, 1'b0, 1'b0, 48'd12, 1'b0, 1'b0, 1'b0);

        // halt, hold, branch while halted, resume
        applyStimulus(0, "br9",     1'b0, 1'b1, 48'd9,  1'b0, 1'b0, 48'd9,  1'b0, 1'b0, 1'b0);
        applyStimulus(0, "halt",    1'b0, 1'b0, 48'd0,  1'b1, 1'b0, 48'd9,  1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, $sformatf("hold%0d", k), (k == 2), 1'b0, 48'd0, 1'b0, 1'b0,
                          48'd9, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(0, "halt_br2",   1'b0, 1'b1, 48'd2, 1'b0, 1'b0, 48'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, "res_and_hr", 1'b0, 1'b0, 48'd0, 1'b1, 1'b1, 48'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, "resume",     1'b0, 1'b0, 48'd0, 1'b0, 1'b1, 48'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "run_after",  1'b0, 1'b0, 48'd0, 1'b0, 1'b0, 48'd3, 1'b0, 1'b0, 1'b0);

        // rejected branch coinciding with a wrapping increment
        applyStimulus(0, "br31",       1'b0, 1'b1, 48'd31, 1'b0, 1'b0, 48'd31, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "bad_wrap",   1'b0, 1'b1, 48'd50, 1'b0, 1'b0, 48'd0,  1'b0, 1'b1, 1'b1);

        // legal branch together with halt_req, then reset while halted
        applyStimulus(0, "br17_halt",  1'b0, 1'b1, 48'd17, 1'b1, 1'b0, 48'd17, 1'b1, 1'b0, 1'b0);
        doReset("reset_halted");
`ifdef PC_WRAP_COUNT_EN
        #2;
        checkOutput("wrap_count_reset2", PCW'(bus0.wrap_count), 48'd0);
`endif
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(0, $sformatf("run64_%0d", k), 1'b0, 1'b0, 48'd0, 1'b0, 1'b0,
                          PCW'(k % 32), 1'b0, ((k % 32) == 0), 1'b0);
        end
`ifdef PC_WRAP_COUNT_EN
        #2;
        checkOutput("wrap_count_64", PCW'(bus0.wrap_count), 48'd2);
`endif

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", PCW'(sb.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
